router_port_drain: RTL and testbench
====================================

// Module: router_port_drain
// PURPOSE
//  Read-side client for one router output port. Drains the port FIFO (read_enb on vld_out),
//  parses header/payload/parity, checks parity and destination, forwards payload over a
//  valid/ready stream. Keeps the port serviced so the synchronizer's 30-cycle idle soft reset
//  fires only when the sink really stalls; survives that soft reset mid-packet.
// PARAMETERS
//  DATA_W   8      FIFO/stream byte width; header = {len[7:2], addr[1:0]}
//  PORT_ID  2'b00  expected header addr; mismatch sets misroute
//  CNT_W    16     statistics counter width (ROUTER_DRAIN_STATS_EN only)
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  vld_out      in   1       port FIFO not empty
//  data_out     in   DATA_W  FIFO read data, valid 1 cycle after read_enb
//  soft_reset   in   1       port soft reset from synchronizer; flushes FIFO
//  read_enb     out  1       FIFO read strobe
//  m_valid      out  1       payload byte valid to sink
//  m_data       out  DATA_W  payload byte
//  m_last       out  1       last payload byte of packet
//  m_ready      in   1       sink accept
//  pkt_done     out  1       1-cycle pulse after parity byte checked
//  pkt_len      out  6       length of last completed packet (held)
//  parity_err   out  1       with pkt_done: XOR(header,payload) != parity byte
//  misroute     out  1       with pkt_done: header addr != PORT_ID
//  pkt_abort    out  1       1-cycle pulse: soft_reset hit a packet in progress
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, skid empty, parity acc 0, in_flight 0.
//  - FSM: IDLE -> HDR (vld_out=1 & not in_flight: read_enb=1) -> HDR captures header at read
//    latency; len=hdr[7:2]; len=0 -> PAR else PLD. PLD: read_enb=1 only when vld_out & skid free
//    slots > in_flight; after len bytes captured -> PAR: read parity byte -> DONE (pkt_done
//    pulse, pkt_len/parity_err/misroute updated) -> IDLE.
//  - In-flight: at most 1 outstanding read; byte captured on cycle after read_enb.
//  - Parity: acc <= acc ^ byte for header and each payload byte; compared with parity byte.
//  - Stream: m_valid/m_data/m_last from skid head; byte leaves on m_valid & m_ready.
//    m_valid never drops without handshake; m_data stable while m_valid & !m_ready.
//  - Backpressure: skid full -> read_enb=0; synchronizer soft reset is legitimate then.
//  - soft_reset (any state): FSM -> IDLE, in_flight byte discarded, acc cleared; if state !=
//    IDLE pkt_abort pulses next cycle; skid bytes already emitted to stream remain, the
//    queued packet's tail gets m_last forced on last queued byte (len truncated). No pkt_done.
//  - vld_out low mid-packet: wait (no timeout here); read_enb=0.
//  - reset mid-operation overrides soft_reset; everything to reset values in same cycle.
//  - pkt_done and pkt_abort never pulse on the same cycle.
// CONFIGURATION
//  ROUTER_DRAIN_STATS_EN defined: adds outputs pkt_cnt, err_cnt, abort_cnt (CNT_W each),
//   saturating at all-ones, cleared by reset only. Undefined: ports and counters absent,
//   all other behaviour identical.
// STRUCTURE
//  router_pkg: DATA_W default, header field positions (LEN_MSB/LSB, ADDR_MSB/LSB), drain FSM
//   state enum {IDLE,HDR,PLD,PAR,DONE}.
//  Sub-module router_drain_skid: 2-entry FIFO {data,last}, valid/ready out, free-slot count.
// TESTING
//  1 hdr 8'h0C(len3,addr0), payload 11,22,33, parity 0C^11^22^33=0C -> m_data 11,22,33,
//    m_last on 33, pkt_done, pkt_len=3, parity_err=0, misroute=0.
//  2 same packet, parity byte 8'hFF -> pkt_done with parity_err=1; stream data unchanged.
//  3 hdr 8'h05(len1,addr1), PORT_ID=0 -> misroute=1 at pkt_done.
//  4 len 20 packet, m_ready=0 for 40 cycles -> read_enb=0 once skid full; no data lost/dup;
//    after m_ready=1 all 20 bytes in order.
//  5 soft_reset during PLD after 2 of 5 bytes -> pkt_abort pulse, m_last on byte 2, no
//    pkt_done; next packet parsed correctly from IDLE.
//  6 STATS_EN: 3 good + 1 parity-error packet -> pkt_cnt=4, err_cnt=1, abort_cnt=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port drain: header layout and drain FSM states.
package router_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Header byte = {len[7:2], addr[1:0]}
  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    DONE
  } drain_st_e;

endpackage

// File: rtl/router_drain_skid.sv
// Two-entry {data,last} FIFO between the port-FIFO reader and the payload stream.
module router_drain_skid #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_force_last,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic [1:0]        o_free
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign o_free  = 2'd2 - r_cnt;
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_push && (r_cnt != 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Truncated packet: the newest queued byte becomes its tail
      if (i_force_last && (r_cnt != 2'd0)) begin
        r_last[~r_wr_ptr] <= 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_port_drain.sv
// Router output-port drain: parses header/payload/parity from the port FIFO onto a stream.
// Optional statistics counters are enabled with the ROUTER_DRAIN_STATS_EN macro.
module router_port_drain
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter logic [1:0]  PORT_ID = 2'b00
`ifdef ROUTER_DRAIN_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  output logic              read_enb,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              parity_err,
  output logic              misroute,
  output logic              pkt_abort
`ifdef ROUTER_DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  abort_cnt
`endif
);

  drain_st_e         r_state;
  drain_st_e         w_state_d;
  logic              r_in_flight;
  logic [DATA_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rd_cnt;
  logic [LEN_W-1:0]  r_cap_cnt;
  logic              r_addr_bad;
  logic [LEN_W-1:0]  r_pkt_len;
  logic              r_parity_err;
  logic              r_misroute;
  logic              r_abort;

  logic              w_rd;
  logic              w_push;
  logic              w_push_last;
  logic              w_par_cap;
  logic              w_force_last;
  logic [1:0]        w_free;
  logic [LEN_W-1:0]  w_hdr_len;

  assign w_hdr_len    = data_out[LEN_MSB:LEN_LSB];
  assign w_force_last = soft_reset && (r_state == PLD);

  always_comb begin
    w_state_d   = r_state;
    w_rd        = 1'b0;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_par_cap   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (vld_out && !r_in_flight) begin
          w_rd      = 1'b1;
          w_state_d = HDR;
        end
      end
      HDR: begin
        if (r_in_flight) begin
          w_state_d = (w_hdr_len == '0) ? PAR : PLD;
        end
      end
      PLD: begin
        // Reserve a skid slot for the byte still in flight before issuing another read
        w_rd = vld_out && (w_free > {1'b0, r_in_flight}) && (r_rd_cnt < r_len);
        if (r_in_flight) begin
          w_push      = 1'b1;
          w_push_last = (r_cap_cnt == (r_len - LEN_W'(1)));
          if (w_push_last) begin
            w_state_d = PAR;
          end
        end
      end
      PAR: begin
        w_rd = vld_out && !r_in_flight;
        if (r_in_flight) begin
          w_par_cap = 1'b1;
          w_state_d = DONE;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (soft_reset) begin
      w_state_d = IDLE;
      w_rd      = 1'b0;
      w_push    = 1'b0;
      w_par_cap = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_flight  <= 1'b0;
      r_acc        <= '0;
      r_len        <= '0;
      r_rd_cnt     <= '0;
      r_cap_cnt    <= '0;
      r_addr_bad   <= 1'b0;
      r_pkt_len    <= '0;
      r_parity_err <= 1'b0;
      r_misroute   <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_in_flight <= w_rd;
      r_abort     <= soft_reset && (r_state != IDLE);
      if (soft_reset) begin
        r_acc     <= '0;
        r_rd_cnt  <= '0;
        r_cap_cnt <= '0;
      end else begin
        if ((r_state == HDR) && r_in_flight) begin
          r_acc      <= data_out;
          r_len      <= w_hdr_len;
          r_addr_bad <= (data_out[ADDR_MSB:ADDR_LSB] != PORT_ID);
          r_rd_cnt   <= '0;
          r_cap_cnt  <= '0;
        end
        if (r_state == PLD) begin
          if (w_rd) begin
            r_rd_cnt <= r_rd_cnt + LEN_W'(1);
          end
          if (r_in_flight) begin
            r_acc     <= r_acc ^ data_out;
            r_cap_cnt <= r_cap_cnt + LEN_W'(1);
          end
        end
        if (w_par_cap) begin
          r_pkt_len    <= r_len;
          r_parity_err <= (r_acc != data_out);
          r_misroute   <= r_addr_bad;
          r_acc        <= '0;
        end
      end
    end
  end

  assign read_enb   = w_rd;
  assign pkt_done   = (r_state == DONE);
  assign pkt_len    = r_pkt_len;
  assign parity_err = pkt_done && r_parity_err;
  assign misroute   = pkt_done && r_misroute;
  assign pkt_abort  = r_abort;

  router_drain_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_data      (data_out),
    .i_last      (w_push_last),
    .i_force_last(w_force_last),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .o_last      (m_last),
    .i_ready     (m_ready),
    .o_free      (w_free)
  );

`ifdef ROUTER_DRAIN_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_abort_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (pkt_done && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
      if (pkt_done && (parity_err || misroute) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (pkt_abort && (r_abort_cnt != '1)) begin
        r_abort_cnt <= r_abort_cnt + CNT_W'(1);
      end
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign err_cnt   = r_err_cnt;
  assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_router_port_drain.sv
// Bench for router_port_drain: port-FIFO model, table of packets, stream/result scoreboard.
module tb_router_port_drain;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out;
  logic [7:0] data_out;
  logic       soft_reset;
  logic       read_enb;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic       parity_err;
  logic       misroute;
  logic       pkt_abort;
`ifdef ROUTER_DRAIN_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [15:0] abort_cnt;
`endif

  router_port_drain dut (
    .clock     (clock),
    .reset     (reset),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .soft_reset(soft_reset),
    .read_enb  (read_enb),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .parity_err(parity_err),
    .misroute  (misroute),
    .pkt_abort (pkt_abort)
`ifdef ROUTER_DRAIN_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int abort_seen = 0;
  int exp_pkts = 0;
  int exp_errs = 0;

  logic [7:0] fifo [$];
  logic [8:0] exp_stream [$];
  logic [7:0] exp_res [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port FIFO model: data valid the cycle after read_enb, flushed by soft_reset
  always @(posedge clock) begin
    if (reset || soft_reset) begin
      fifo.delete();
    end else if (read_enb && (fifo.size() > 0)) begin
      data_out <= fifo.pop_front();
    end
    vld_out <= !reset && (fifo.size() != 0);
  end

  logic       hold_q = 1'b0;
  logic [8:0] hold_val;

  always @(negedge clock) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (exp_stream.size() == 0) chk("stream_extra", {23'd0, m_last, m_data}, 32'h1ff);
        else chk("stream_byte", {23'd0, m_last, m_data}, {23'd0, exp_stream.pop_front()});
      end
      if (hold_q && m_valid) chk("stream_stable", {23'd0, m_last, m_data}, {23'd0, hold_val});
      hold_q   = m_valid && !m_ready;
      hold_val = {m_last, m_data};
      if (pkt_done) begin
        if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
        else chk("pkt_result", {24'd0, pkt_len, parity_err, misroute}, {24'd0, exp_res.pop_front()});
      end
      if (pkt_abort) abort_seen++;
      if (pkt_done && pkt_abort) chk("done_abort_overlap", 1, 0);
    end
  end

  typedef struct {
    logic [7:0]       hdr;
    logic [3:0][7:0]  pl;
    logic [7:0]       par;
    logic [5:0]       len;
    logic             perr;
    logic             mis;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input logic [7:0] hdr, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] par, input logic [5:0] len, input logic perr,
                         input logic mis);
    vecs[i].hdr = hdr;
    vecs[i].pl[0] = b0;
    vecs[i].pl[1] = b1;
    vecs[i].pl[2] = b2;
    vecs[i].pl[3] = b3;
    vecs[i].par = par;
    vecs[i].len = len;
    vecs[i].perr = perr;
    vecs[i].mis = mis;
  endtask

  task automatic send_vec(input int i);
    fifo.push_back(vecs[i].hdr);
    for (int k = 0; k < int'(vecs[i].len); k++) begin
      fifo.push_back(vecs[i].pl[k]);
      exp_stream.push_back({(k == int'(vecs[i].len) - 1), vecs[i].pl[k]});
    end
    fifo.push_back(vecs[i].par);
    exp_res.push_back({vecs[i].len, vecs[i].perr, vecs[i].mis});
    exp_pkts++;
    if (vecs[i].perr || vecs[i].mis) exp_errs++;
  endtask

  task automatic wait_drain(input int max_cyc, input bit rnd);
    int n = 0;
    while ((exp_stream.size() != 0 || exp_res.size() != 0) && n < max_cyc) begin
      @(posedge clock); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (n >= max_cyc) chk("drain_timeout", 1, 0);
    @(posedge clock); #1;
    m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] par;
    int rd_hi;
    int ab0;

    set_vec(0, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0C, 6'd3, 1'b0, 1'b0);
    set_vec(1, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h00, 8'hFF, 6'd3, 1'b1, 1'b0);
    set_vec(2, 8'h05, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hAF, 6'd1, 1'b0, 1'b1);
    set_vec(3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6'd0, 1'b0, 1'b0);
    set_vec(4, 8'h0A, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'hF5, 6'd2, 1'b0, 1'b1);
    set_vec(5, 8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h1F, 6'd4, 1'b0, 1'b0);

    reset = 1'b1;
    soft_reset = 1'b0;
    m_ready = 1'b1;
    data_out = 8'h00;
    vld_out = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_read_enb", {31'd0, read_enb}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 0);
    chk("rst_pkt_len", {26'd0, pkt_len}, 0);
    chk("rst_flags", {30'd0, parity_err, misroute}, 0);
    chk("rst_pkt_abort", {31'd0, pkt_abort}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      send_vec(i);
      wait_drain(300, (i % 2) == 1);
    end

    // Long packet under sustained backpressure
    par = 8'h50;
    fifo.push_back(8'h50);
    for (int k = 0; k < 20; k++) begin
      fifo.push_back(8'h40 + 8'(k));
      exp_stream.push_back({(k == 19), 8'h40 + 8'(k)});
      par = par ^ (8'h40 + 8'(k));
    end
    fifo.push_back(par);
    exp_res.push_back({6'd20, 1'b0, 1'b0});
    exp_pkts++;
    m_ready = 1'b0;
    rd_hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (c >= 10 && read_enb) rd_hi++;
    end
    chk("bp_read_enb_low", rd_hi, 0);
    chk("bp_m_valid_held", {31'd0, m_valid}, 1);
    chk("bp_nothing_emitted", exp_stream.size(), 20);
    wait_drain(300, 1'b0);

    // Soft reset in payload after two of five bytes are queued
    ab0 = abort_seen;
    m_ready = 1'b0;
    fifo.push_back(8'h14);
    for (int k = 1; k <= 5; k++) fifo.push_back(8'hB0 + 8'(k));
    fifo.push_back(8'h00);
    exp_stream.push_back({1'b0, 8'hB1});
    exp_stream.push_back({1'b1, 8'hB2});
    repeat (12) @(posedge clock);
    #1;
    chk("sr_skid_holding", {31'd0, m_valid}, 1);
    soft_reset = 1'b1;
    @(posedge clock); #1;
    soft_reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("sr_abort_pulse", abort_seen - ab0, 1);
    chk("sr_no_done", exp_res.size(), 0);
    wait_drain(100, 1'b0);
    chk("sr_abort_single", abort_seen - ab0, 1);

    send_vec(0);
    wait_drain(300, 1'b0);

`ifdef ROUTER_DRAIN_STATS_EN
    chk("stat_pkt_cnt", {16'd0, pkt_cnt}, exp_pkts);
    chk("stat_err_cnt", {16'd0, err_cnt}, exp_errs);
    chk("stat_abort_cnt", {16'd0, abort_cnt}, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
